conv_window_gen: RTL and testbench

- Downstream stage of the 28-pixel line buffer. It consumes three complete stored rows and sweeps a 3x3 window across them.
- Emits one 9-pixel window per accepted cycle to the MAC array, with valid/ready handshaking.
- Zero padding at the left and right edges is optional.
- Detects row groups it had to drop because upstream has no backpressure.

---
 rtl/conv_window_gen.sv | 137 +++++++++++++
 tb/tb_conv_window_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - 3x3 sliding-window generator over three captured rows
// Sweeps one window per accepted handshake; optional zero padding at row edges.
module conv_window_gen #(
  parameter int W    = 16,
  parameter int COLS = 28,
  parameter int PAD  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [W*COLS-1:0]         row0_in,
  input  logic [W*COLS-1:0]         row1_in,
  input  logic [W*COLS-1:0]         row2_in,
  input  logic                      rows_valid,
  output logic                      rows_ready,
  output logic [9*W-1:0]            win_data,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [$clog2(COLS)-1:0]   win_col,
  output logic                      win_last,
  output logic                      overflow
);

  localparam int NWIN  = (PAD != 0) ? COLS : COLS - 2;
  localparam int CW    = $clog2(COLS);
  localparam int PCOLS = COLS + 2;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [W*COLS-1:0] row_q [3];
  logic            overflow_q;
  logic            transfer;
  logic            at_last;
  logic            capture;

  assign at_last = (col_q == CW'(NWIN - 1));

  always_comb begin
    win_valid  = 1'b0;
    transfer   = 1'b0;
    rows_ready = 1'b0;
    capture    = 1'b0;
    state_d    = state_q;
    col_d      = col_q;
    case (state_q)
      IDLE: begin
        rows_ready = 1'b1;
        capture    = rows_valid;
        if (capture) begin
          state_d = SWEEP;
          col_d   = '0;
        end
      end
      SWEEP: begin
        win_valid  = 1'b1;
        transfer   = win_ready;
        rows_ready = transfer && at_last;
        capture    = rows_valid && rows_ready;
        if (transfer) begin
          if (at_last) begin
            // a group landing on the final transfer restarts the sweep seamlessly
            col_d   = '0;
            state_d = capture ? SWEEP : IDLE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        col_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      overflow_q <= 1'b0;
      row_q[0]   <= '0;
      row_q[1]   <= '0;
      row_q[2]   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      if (rows_valid && !rows_ready) begin
        overflow_q <= 1'b1;
      end
      if (capture) begin
        row_q[0] <= row0_in;
        row_q[1] <= row1_in;
        row_q[2] <= row2_in;
      end
    end
  end

  assign win_col  = col_q;
  assign win_last = win_valid && at_last;
  assign overflow = overflow_q;

  // Pixel view with a zero column on each side; index p maps to stored column p-1.
  logic [W-1:0] pix [3][PCOLS];

  for (genvar r = 0; r < 3; r++) begin : g_pix_row
    for (genvar p = 0; p < PCOLS; p++) begin : g_pix_col
      if (p == 0 || p == PCOLS - 1) begin : g_zero
        assign pix[r][p] = '0;
      end else begin : g_data
        assign pix[r][p] = row_q[r][W*(p-1) +: W];
      end
    end
  end

  logic [9*W-1:0] win_all [NWIN];

  for (genvar j = 0; j < NWIN; j++) begin : g_win
    for (genvar r = 0; r < 3; r++) begin : g_tap_row
      for (genvar c = 0; c < 3; c++) begin : g_tap_col
        localparam int PIDX = (PAD != 0) ? j + c : j + 1 + c;
        assign win_all[j][W*(3*r+c) +: W] = pix[r][PIDX];
      end
    end
  end

  always_comb begin
    win_data = '0;
    if (col_q < CW'(NWIN)) begin
      win_data = win_all[col_q];
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - directed bench for conv_window_gen, PAD=0 and PAD=1 instances
// Inputs driven and outputs sampled on the falling clock edge.
module tb_conv_window_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic [447:0] row0, row1, row2;
  logic         rows_valid;
  logic         win_ready;

  logic         rr0, wv0, wl0, ov0;
  logic [143:0] wd0;
  logic [4:0]   wc0;
  logic         rr1, wv1, wl1, ov1;
  logic [143:0] wd1;
  logic [4:0]   wc1;

  int n_pass  = 0;
  int n_total = 0;

  logic [143:0] cap0 [26];
  logic [143:0] cap1 [28];

  typedef struct {
    bit          pad;
    int          win;
    int          tap;
    logic [15:0] exp;
  } spot_t;

  spot_t spots [14];

  always #5 clk = ~clk;

  conv_window_gen #(.W(16), .COLS(28), .PAD(0)) dut0 (
    .clk(clk), .rst(rst), .row0_in(row0), .row1_in(row1), .row2_in(row2),
    .rows_valid(rows_valid), .rows_ready(rr0), .win_data(wd0), .win_valid(wv0),
    .win_ready(win_ready), .win_col(wc0), .win_last(wl0), .overflow(ov0)
  );

  conv_window_gen #(.W(16), .COLS(28), .PAD(1)) dut1 (
    .clk(clk), .rst(rst), .row0_in(row0), .row1_in(row1), .row2_in(row2),
    .rows_valid(rows_valid), .rows_ready(rr1), .win_data(wd1), .win_valid(wv1),
    .win_ready(win_ready), .win_col(wc1), .win_last(wl1), .overflow(ov1)
  );

  function automatic logic [15:0] pix(int kind, int r, int c);
    case (kind)
      0:       return 16'((r << 8) | c);
      1:       return 16'hFFFF;
      default: return 16'(32'hA000 | (r << 8) | c);
    endcase
  endfunction

  function automatic logic [143:0] model(bit pad, int j, int kind);
    logic [143:0] m;
    m = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        int col;
        col = pad ? j - 1 + c : j + c;
        if (col >= 0 && col < 28) m[16*(3*r+c) +: 16] = pix(kind, r, col);
      end
    end
    return m;
  endfunction

  task automatic load(int kind);
    for (int c = 0; c < 28; c++) begin
      row0[16*c +: 16] = pix(kind, 0, c);
      row1[16*c +: 16] = pix(kind, 1, c);
      row2[16*c +: 16] = pix(kind, 2, c);
    end
  endtask

  task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rows_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    spots[0]  = '{0, 0, 4, 16'h0101};
    spots[1]  = '{0, 25, 8, 16'h021B};
    spots[2]  = '{0, 0, 0, 16'h0000};
    spots[3]  = '{0, 13, 3, 16'h010D};
    spots[4]  = '{1, 0, 0, 16'h0000};
    spots[5]  = '{1, 0, 3, 16'h0000};
    spots[6]  = '{1, 0, 6, 16'h0000};
    spots[7]  = '{1, 0, 4, 16'h0100};
    spots[8]  = '{1, 27, 2, 16'h0000};
    spots[9]  = '{1, 27, 5, 16'h0000};
    spots[10] = '{1, 27, 8, 16'h0000};
    spots[11] = '{1, 27, 4, 16'h011B};
    spots[12] = '{1, 27, 7, 16'h021B};
    spots[13] = '{1, 5, 0, 16'h0004};

    rst = 1'b0;
    rows_valid = 1'b0;
    win_ready = 1'b0;
    row0 = '0; row1 = '0; row2 = '0;

    // reset with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 14; k++) begin
        row0[32*k +: 32] = $urandom;
        row1[32*k +: 32] = $urandom;
        row2[32*k +: 32] = $urandom;
      end
      rows_valid = 1'($urandom_range(0, 1));
      win_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("rst_valid", wv0, 0);
    chk("rst_data", wd0, 0);
    chk("rst_col_last", {wc0, wl0}, 0);
    chk("rst_overflow", ov0, 0);
    chk("rst_rows_ready", rr0, 1);
    rst = 1'b1;
    rows_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rel_idle", {wv0, wl0, wc0, ov0, rr0}, {1'b0, 1'b0, 5'd0, 1'b0, 1'b1});
    chk("rel_data", wd0, 0);

    // full sweep, PAD=0, consumer always ready
    load(0);
    rows_valid = 1'b1;
    win_ready = 1'b1;
    @(negedge clk);
    rows_valid = 1'b0;
    for (int j = 0; j < 26; j++) begin
      chk($sformatf("sweep_ctl_%0d", j), {wv0, wl0, wc0}, {1'b1, 1'(j == 25), 5'(j)});
      chk($sformatf("sweep_data_%0d", j), wd0, model(0, j, 0));
      cap0[j] = wd0;
      if (j == 25) chk("sweep_rows_ready_last", rr0, 1);
      @(negedge clk);
    end
    chk("sweep_done_valid", wv0, 0);

    // random backpressure: 26 in-order transfers, stable while stalled
    begin
      int n;
      int cyc;
      logic held;
      logic [149:0] hd;
      n = 0; cyc = 0; held = 1'b0; hd = '0;
      load(0);
      rows_valid = 1'b1;
      win_ready = 1'b0;
      @(negedge clk);
      rows_valid = 1'b0;
      while (n < 26 && cyc < 400) begin
        if (held) chk($sformatf("bp_hold_%0d", cyc), {wd0, wc0, wl0}, hd);
        win_ready = 1'($urandom_range(0, 1));
        if (wv0 && win_ready) begin
          chk($sformatf("bp_xfer_%0d", n), {wc0, wd0}, {5'(n), model(0, n, 0)});
          n++;
          held = 1'b0;
        end else begin
          held = wv0;
          hd = {wd0, wc0, wl0};
        end
        cyc++;
        @(negedge clk);
      end
      chk("bp_count", n, 26);
      chk("bp_done_valid", wv0, 0);
      chk("bp_no_overflow", ov0, 0);
      win_ready = 1'b1;
    end

    // overflow: a group offered mid-sweep is dropped
    load(0);
    rows_valid = 1'b1;
    @(negedge clk);
    rows_valid = 1'b0;
    for (int j = 0; j < 26; j++) begin
      rows_valid = 1'b0;
      chk($sformatf("ovf_col_%0d", j), {wv0, wc0}, {1'b1, 5'(j)});
      chk($sformatf("ovf_data_%0d", j), wd0, model(0, j, 0));
      if (j == 10) begin
        chk("ovf_before", ov0, 0);
        load(1);
        rows_valid = 1'b1;
      end
      if (j == 11) chk("ovf_set", ov0, 1);
      @(negedge clk);
    end
    rows_valid = 1'b0;
    chk("ovf_after", {wv0, ov0}, {1'b0, 1'b1});

    // back-to-back groups
    do_reset();
    chk("b2b_ovf_cleared", ov0, 0);
    load(0);
    rows_valid = 1'b1;
    @(negedge clk);
    rows_valid = 1'b0;
    for (int j = 0; j < 26; j++) begin
      chk($sformatf("b2b_a_%0d", j), {wv0, wc0}, {1'b1, 5'(j)});
      if (j == 25) begin
        chk("b2b_rows_ready", rr0, 1);
        load(2);
        rows_valid = 1'b1;
      end
      @(negedge clk);
    end
    rows_valid = 1'b0;
    for (int j = 0; j < 26; j++) begin
      chk($sformatf("b2b_b_ctl_%0d", j), {wv0, wl0, wc0, ov0}, {1'b1, 1'(j == 25), 5'(j), 1'b0});
      chk($sformatf("b2b_b_data_%0d", j), wd0, model(0, j, 2));
      @(negedge clk);
    end
    chk("b2b_done_valid", wv0, 0);

    // PAD=1 sweep
    do_reset();
    load(0);
    rows_valid = 1'b1;
    @(negedge clk);
    rows_valid = 1'b0;
    for (int j = 0; j < 28; j++) begin
      chk($sformatf("pad_ctl_%0d", j), {wv1, wl1, wc1}, {1'b1, 1'(j == 27), 5'(j)});
      chk($sformatf("pad_data_%0d", j), wd1, model(1, j, 0));
      cap1[j] = wd1;
      @(negedge clk);
    end
    chk("pad_done_valid", wv1, 0);

    for (int i = 0; i < 14; i++) begin
      logic [143:0] w;
      w = spots[i].pad ? cap1[spots[i].win] : cap0[spots[i].win];
      chk($sformatf("spot_p%0d_w%0d_t%0d", spots[i].pad, spots[i].win, spots[i].tap),
          w[16*spots[i].tap +: 16], spots[i].exp);
    end

    // asynchronous reset mid-sweep
    rows_valid = 1'b1;
    @(negedge clk);
    rows_valid = 1'b0;
    for (int j = 0; j < 15; j++) @(negedge clk);
    chk("arst_at_col", {wv1, wc1}, {1'b1, 5'd15});
    rst = 1'b0;
    #1;
    chk("arst_immediate", {wv1, wl1, wc1, ov1}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("arst_idle", {wv1, wc1, rr1}, {1'b0, 5'd0, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
